// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 5-stage RISC-V pipeline.
// Owns the program counter. Issues at most one outstanding request to
// instruction memory at a time. Returned words go to a one-entry output
// register (o_valid/o_instruction/o_pc). A one-entry skid buffer catches the
// single response that can land while the consumer is stalled.
//
// Handshakes:
//   - Memory request: o_imem_req/o_imem_addr are held until i_imem_gnt is
//     seen in the same cycle (req & gnt = accepted). After that, exactly one
//     i_imem_rvalid follows, at least one cycle later.
//   - Downstream: the entry on o_valid/o_instruction/o_pc is taken in any
//     cycle with o_valid & !i_stall. With i_stall high it holds unchanged.
//   - i_redirect is a single-cycle pulse. It flushes every buffered or
//     in-flight instruction and restarts fetch at i_redirect_pc.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   i_stall             downstream cannot accept this cycle
//   i_redirect          flush and restart at i_redirect_pc (bits [1:0] ignored)
//   i_redirect_pc       redirect target
//   o_imem_req          fetch request (combinational)
//   o_imem_addr         word-aligned fetch address (combinational)
//   i_imem_gnt          request accepted this cycle
//   i_imem_rvalid       response valid
//   i_imem_rdata        response instruction word
//   o_valid             o_instruction/o_pc hold a real instruction
//   o_instruction       instruction to IF/ID (NOP_INSTR when !o_valid)
//   o_pc                PC of o_instruction
//   fsm_state           debug view of the fetch FSM (0 FETCH, 1 WAIT, 2 DROP)
module fetch_stage #(
  parameter int                           INSTRUCTION_WIDTH = 32,
  parameter logic [31:0]                  RESET_PC          = 32'h0000_0000,
  parameter logic [INSTRUCTION_WIDTH-1:0] NOP_INSTR         = 32'h0000_0013
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_stall,
  input  logic                         i_redirect,
  input  logic [31:0]                  i_redirect_pc,
  output logic                         o_imem_req,
  output logic [31:0]                  o_imem_addr,
  input  logic                         i_imem_gnt,
  input  logic                         i_imem_rvalid,
  input  logic [INSTRUCTION_WIDTH-1:0] i_imem_rdata,
  output logic                         o_valid,
  output logic [INSTRUCTION_WIDTH-1:0] o_instruction,
  output logic [31:0]                  o_pc,
  output logic [1:0]                   fsm_state
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t                         state;
  state_t                         state_next;
  logic [31:0]                    pc;
  logic [31:0]                    req_pc;
  logic                           skid_valid;
  logic [INSTRUCTION_WIDTH-1:0]   skid_instr;
  logic [31:0]                    skid_pc;

  logic issue;
  logic accepted;
  logic deliver;
  logic consume;

  // No new request while the skid is occupied. This bounds the buffering
  // needed during a stall to the output entry plus the skid.
  assign issue    = (state == FETCH) && !skid_valid;
  assign accepted = issue && i_imem_gnt;
  // A response that coincides with a redirect is discarded, not delivered.
  assign deliver  = (state == WAIT) && i_imem_rvalid && !i_redirect;
  assign consume  = o_valid && !i_stall;

  assign o_imem_req  = issue;
  assign o_imem_addr = pc;
  assign fsm_state   = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH: begin
        if (i_redirect) begin
          // A request accepted in the redirect cycle still returns data,
          // and that data belongs to the old path.
          state_next = accepted ? DROP : FETCH;
        end else if (accepted) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (i_redirect) begin
          state_next = i_imem_rvalid ? FETCH : DROP;
        end else if (i_imem_rvalid) begin
          state_next = FETCH;
        end
      end
      DROP: begin
        // A redirect here only moves pc. The stage still waits for the one
        // outstanding response. If that response lands in the same cycle,
        // the wait is over.
        if (i_imem_rvalid) begin
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc            <= RESET_PC;
      req_pc        <= RESET_PC;
      o_valid       <= 1'b0;
      o_instruction <= NOP_INSTR;
      o_pc          <= RESET_PC;
      skid_valid    <= 1'b0;
      skid_instr    <= NOP_INSTR;
      skid_pc       <= RESET_PC;
    end else begin
      if (i_redirect) begin
        pc <= i_redirect_pc & 32'hFFFF_FFFC;
      end else if (accepted) begin
        pc <= pc + 32'd4;
      end

      if (accepted) begin
        req_pc <= pc;
      end

      if (i_redirect) begin
        o_valid       <= 1'b0;
        o_instruction <= NOP_INSTR;
        skid_valid    <= 1'b0;
      end else if (consume) begin
        if (skid_valid) begin
          o_instruction <= skid_instr;
          o_pc          <= skid_pc;
          skid_valid    <= deliver;
          if (deliver) begin
            skid_instr <= i_imem_rdata;
            skid_pc    <= req_pc;
          end
        end else if (deliver) begin
          o_instruction <= i_imem_rdata;
          o_pc          <= req_pc;
        end else begin
          o_valid       <= 1'b0;
          o_instruction <= NOP_INSTR;
        end
      end else if (deliver) begin
        if (!o_valid) begin
          o_valid       <= 1'b1;
          o_instruction <= i_imem_rdata;
          o_pc          <= req_pc;
        end else begin
          skid_valid <= 1'b1;
          skid_instr <= i_imem_rdata;
          skid_pc    <= req_pc;
        end
      end
    end
  end

endmodule
